// File: rtl/alu_exec_if.sv
// Issue/result bundle between the register-read stage and the execute unit.
// The master drives operations in; the slave (execute unit) returns results.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       func;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, alu_op, func, op_a, op_b, shamt,
        input  in_ready, out_valid, result, zero, ovf, illegal
    );

    modport slave (
        input  in_valid, alu_op, func, op_a, op_b, shamt,
        output in_ready, out_valid, result, zero, ovf, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-op decode plus registered datapath. Most ops finish in one
// cycle; mul runs on a WIDTH-step shift-add engine and holds in_ready low.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);
    localparam int               CNT_W    = SHW + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
    localparam logic [5:0] F_JR   = 6'b001000, F_MUL  = 6'b011000;
    localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001, F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011, F_AND  = 6'b100100, F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111, F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [5:0] O_BNE  = 6'b000101, O_ADDI = 6'b001000, O_ADDIU = 6'b001001;
    localparam logic [5:0] O_SLTI = 6'b001010, O_SLTIU = 6'b001011, O_ANDI = 6'b001100;
    localparam logic [5:0] O_ORI  = 6'b001101, O_XORI = 6'b001110, O_LUI  = 6'b001111;
    localparam logic [5:0] O_MUL  = 6'b011100;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mplier_q, acc_q, acc_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               out_valid_q, zero_q, ovf_q, illegal_q;

    logic [WIDTH-1:0]   sum, diff, alu_res;
    logic               add_ovf, sub_ovf, lt_s, lt_u;
    logic               alu_ovf, dec_illegal, dec_mul;

    assign sum     = bus.op_a + bus.op_b;
    assign diff    = bus.op_a - bus.op_b;
    assign add_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) && (sum[WIDTH-1]  != bus.op_a[WIDTH-1]);
    assign sub_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) && (diff[WIDTH-1] != bus.op_a[WIDTH-1]);
    assign lt_s    = $signed(bus.op_a) < $signed(bus.op_b);
    assign lt_u    = bus.op_a < bus.op_b;

    // Undecodable combinations fall through to the defaults: result 0, illegal set.
    always_comb begin
        alu_res     = '0;
        alu_ovf     = 1'b0;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        case (bus.alu_op)
            2'b00: begin alu_res = sum;  alu_ovf = add_ovf; end
            2'b01: begin alu_res = diff; alu_ovf = sub_ovf; end
            2'b10: begin
                case (bus.func)
                    F_ADD:  begin alu_res = sum;  alu_ovf = add_ovf; end
                    F_ADDU: alu_res = sum;
                    F_SUB:  begin alu_res = diff; alu_ovf = sub_ovf; end
                    F_SUBU: alu_res = diff;
                    F_AND:  alu_res = bus.op_a & bus.op_b;
                    F_OR:   alu_res = bus.op_a | bus.op_b;
                    F_XOR:  alu_res = bus.op_a ^ bus.op_b;
                    F_NOR:  alu_res = ~(bus.op_a | bus.op_b);
                    F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
                    F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
                    F_SLL:  alu_res = bus.op_b << bus.shamt;
                    F_SRL:  alu_res = bus.op_b >> bus.shamt;
                    F_SRA:  alu_res = $signed(bus.op_b) >>> bus.shamt;
                    F_JR:   alu_res = bus.op_a;
                    F_MUL:  dec_mul = 1'b1;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: begin
                case (bus.func)
                    O_ADDI:  begin alu_res = sum; alu_ovf = add_ovf; end
                    O_ADDIU: alu_res = sum;
                    O_ANDI:  alu_res = bus.op_a & bus.op_b;
                    O_ORI:   alu_res = bus.op_a | bus.op_b;
                    O_XORI:  alu_res = bus.op_a ^ bus.op_b;
                    O_SLTI:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
                    O_SLTIU: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
                    O_LUI:   alu_res = bus.op_b << (WIDTH/2);
                    O_BNE:   alu_res = diff;
                    O_MUL:   dec_mul = 1'b1;
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid && dec_mul) state_d = MUL;
            MUL:     if (cnt_q == CNT_INIT'(1))   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle results register on the accept edge; mul results on its last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (state_q == IDLE) begin
                if (bus.in_valid) begin
                    if (dec_mul) begin
                        mcand_q  <= bus.op_a;
                        mplier_q <= bus.op_b;
                        acc_q    <= '0;
                        cnt_q    <= CNT_INIT;
                    end else begin
                        result_q    <= alu_res;
                        zero_q      <= (alu_res == '0);
                        ovf_q       <= alu_ovf;
                        illegal_q   <= dec_illegal;
                        out_valid_q <= 1'b1;
                    end
                end
            end else begin
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                acc_q    <= acc_next;
                cnt_q    <= cnt_q - CNT_INIT'(1);
                if (cnt_q == CNT_INIT'(1)) begin
                    result_q    <= acc_next;
                    zero_q      <= (acc_next == '0);
                    ovf_q       <= 1'b0;
                    illegal_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised self-checking bench for alu_exec_unit against a plain-arithmetic
// reference model; a second 8-bit instance covers the narrow multiplier.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_exec_if #(.WIDTH(32)) bus ();
    alu_exec_if #(.WIDTH(8))  bus8 ();

    alu_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_exec_unit #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Behavioural model: what each MIPS op means, in 64-bit integer arithmetic.
    function automatic void refModel(input logic [1:0] op, input logic [5:0] fn,
                                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                                     output logic [31:0] res, output bit ov, output bit il, output bit is_mul);
        longint sa, sb, s;
        logic [63:0] prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        prod = {32'd0, a} * {32'd0, b};
        res = 32'd0; ov = 0; il = 0; is_mul = 0;
        if (op == 2'b00 || (op == 2'b10 && (fn == 6'd32 || fn == 6'd33)) || (op == 2'b11 && (fn == 6'd8 || fn == 6'd9))) begin
            s = sa + sb;
            res = 32'(s);
            ov = (op == 2'b00 || (op == 2'b10 && fn == 6'd32) || (op == 2'b11 && fn == 6'd8))
                 && (s > 64'sd2147483647 || s < -64'sd2147483648);
        end else if (op == 2'b01 || (op == 2'b10 && (fn == 6'd34 || fn == 6'd35)) || (op == 2'b11 && fn == 6'd5)) begin
            s = sa - sb;
            res = 32'(s);
            ov = (op == 2'b01 || (op == 2'b10 && fn == 6'd34)) && (s > 64'sd2147483647 || s < -64'sd2147483648);
        end else if (op == 2'b10) begin
            case (fn)
                6'd36: res = a & b;
                6'd37: res = a | b;
                6'd38: res = a ^ b;
                6'd39: res = ~(a | b);
                6'd42: res = (sa < sb) ? 32'd1 : 32'd0;
                6'd43: res = (a < b) ? 32'd1 : 32'd0;
                6'd0:  res = 32'(longint'(b) * (64'sd1 << sh));
                6'd2:  res = 32'(longint'(b) / (64'sd1 << sh));
                6'd3:  res = 32'(sb >>> sh);
                6'd8:  res = a;
                6'd24: begin res = prod[31:0]; is_mul = 1; end
                default: il = 1;
            endcase
        end else begin
            case (fn)
                6'd12: res = a & b;
                6'd13: res = a | b;
                6'd14: res = a ^ b;
                6'd10: res = (sa < sb) ? 32'd1 : 32'd0;
                6'd11: res = (a < b) ? 32'd1 : 32'd0;
                6'd15: res = 32'(longint'(b) * 65536);
                6'd28: begin res = prod[31:0]; is_mul = 1; end
                default: il = 1;
            endcase
        end
    endfunction

    // Presents one op; single-cycle ops leave in_valid high so calls chain back-to-back.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                                 input bit hold_next);
        logic [31:0] er;
        bit eo, ei, em;
        int cycles;
        refModel(op, fn, a, b, sh, er, eo, ei, em);
        bus.alu_op = op; bus.func = fn; bus.op_a = a; bus.op_b = b; bus.shamt = sh;
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        if (em) begin
            if (hold_next) begin
                bus.alu_op = 2'b00; bus.op_a = 32'd5; bus.op_b = 32'd9;
            end else begin
                bus.in_valid = 1'b0;
            end
            cycles = 0;
            while (!bus.out_valid && cycles < 100) begin
                checkOutput("mul_busy_ready", bus.in_ready, 0);
                @(posedge clk); @(negedge clk);
                cycles++;
            end
            checkOutput("mul_latency", cycles, 32);
            checkOutput("mul_ready_back", bus.in_ready, 1);
            if (hold_next) begin
                checkOutput("mul_result", bus.result, er);
                @(posedge clk); @(negedge clk);
                checkOutput("held_op_valid", bus.out_valid, 1);
                checkOutput("held_op_result", bus.result, 32'd14);
                bus.in_valid = 1'b0;
                return;
            end
        end
        checkOutput("out_valid", bus.out_valid, 1);
        checkOutput("result", bus.result, er);
        checkOutput("zero", bus.zero, (er == 32'd0));
        checkOutput("ovf", bus.ovf, eo);
        checkOutput("illegal", bus.illegal, ei);
    endtask

    task automatic idleCycle();
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        checkOutput("valid_drop", bus.out_valid, 0);
    endtask

    logic [5:0] r_funcs [15];
    logic [5:0] i_funcs [10];

    initial begin
        int strays, cycles;
        logic [1:0] op;
        logic [5:0] fn;
        r_funcs = '{6'd0, 6'd2, 6'd3, 6'd8, 6'd24, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43};
        i_funcs = '{6'd5, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd28};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.alu_op = '0; bus.func = '0; bus.op_a = '0; bus.op_b = '0; bus.shamt = '0;
        bus8.in_valid = 1'b0; bus8.alu_op = '0; bus8.func = '0; bus8.op_a = '0; bus8.op_b = '0; bus8.shamt = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", bus.in_ready, 1);
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_result", bus.result, 0);
        checkOutput("rst_zero", bus.zero, 1);
        checkOutput("rst_ovf", bus.ovf, 0);
        checkOutput("rst_illegal", bus.illegal, 0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(2'b10, 6'b100000, 32'h7FFFFFFF, 32'd1, 5'd0, 0);
        checkOutput("add_ovf_result", bus.result, 32'h80000000);
        applyStimulus(2'b10, 6'b101011, 32'hFFFFFFFF, 32'd1, 5'd0, 0);
        checkOutput("sltu_result", bus.result, 32'd0);
        applyStimulus(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 5'd0, 0);
        checkOutput("slt_result", bus.result, 32'd1);
        applyStimulus(2'b10, 6'b000011, 32'd0, 32'h80000000, 5'd4, 0);
        checkOutput("sra_result", bus.result, 32'hF8000000);
        applyStimulus(2'b11, 6'b001111, 32'd0, 32'h1234, 5'd0, 0);
        checkOutput("lui_result", bus.result, 32'h12340000);
        idleCycle();

        applyStimulus(2'b11, 6'b011100, 32'd7, 32'd6, 5'd0, 1);
        idleCycle();
        applyStimulus(2'b10, 6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 0);
        checkOutput("mul_ff_result", bus.result, 32'd1);
        idleCycle();

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) fn = 6'($urandom_range(0, 63));
            else if (op == 2'b10)          fn = r_funcs[$urandom_range(0, 14)];
            else                           fn = i_funcs[$urandom_range(0, 9)];
            applyStimulus(op, fn, $urandom, $urandom, 5'($urandom_range(0, 31)), 0);
            if ($urandom_range(0, 1) == 1) idleCycle();
        end
        idleCycle();

        // Reset mid-multiply must abort it with no late result.
        bus.alu_op = 2'b11; bus.func = 6'b011100; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", bus.in_ready, 1);
        checkOutput("abort_valid", bus.out_valid, 0);
        checkOutput("abort_result", bus.result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        strays = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) strays++;
        end
        checkOutput("abort_no_stray", strays, 0);
        applyStimulus(2'b10, 6'b111111, 32'd11, 32'd22, 5'd0, 0);
        checkOutput("illegal_flag", bus.illegal, 1);
        idleCycle();

        bus8.alu_op = 2'b11; bus8.func = 6'b011100; bus8.op_a = 8'h10; bus8.op_b = 8'h10; bus8.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus8.in_valid = 1'b0;
        cycles = 0;
        while (!bus8.out_valid && cycles < 50) begin
            @(posedge clk); @(negedge clk);
            cycles++;
        end
        checkOutput("mul8_latency", cycles, 8);
        checkOutput("mul8_result", bus8.result, 8'h00);
        checkOutput("mul8_zero", bus8.zero, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
